// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out the change computed by the vending controller. It ejects one coin
// at a time in the order 5, 2, 1 and confirms each coin on the hopper drop
// sensor. An unconfirmed coin is retried up to MAX_RETRY more times before a
// fault is latched.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   load              one-cycle strobe, latches r1/r2/r5 and starts (IDLE only)
//   r1, r2, r5        number of 1-, 2- and 5-unit coins to return
//   coin_seen         hopper drop sensor, already synchronous to clk
//   fault_clr         leaves FAULT and returns to IDLE
//   eject1/2/5        registered solenoid drives, at most one high at a time
//   busy              high whenever the FSM is not in IDLE
//   done              one-cycle pulse once every requested coin is confirmed
//   fault             high while in FAULT
//   rem1, rem2, rem5  coins still owed, kept after a fault for diagnostics
module change_dispenser #(
    parameter int PULSE_LEN   = 4,
    parameter int ACK_TIMEOUT = 32,
    parameter int GAP_LEN     = 2,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    input  logic [3:0] r5,
    input  logic       coin_seen,
    input  logic       fault_clr,
    output logic       eject1,
    output logic       eject2,
    output logic       eject5,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [3:0] rem1,
    output logic [3:0] rem2,
    output logic [3:0] rem5
);

    // One counter is shared by the pulse, timeout and gap phases, so it is
    // sized for the longest of the three.
    localparam int CNT_MAX = (PULSE_LEN > ACK_TIMEOUT)
                           ? ((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN)
                           : ((ACK_TIMEOUT > GAP_LEN) ? ACK_TIMEOUT : GAP_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_EJECT, S_WAIT_ACK, S_GAP, S_DONE, S_FAULT
    } state_t;

    typedef enum logic [1:0] {D1, D2, D5} denom_t;

    state_t             state, state_nxt;
    denom_t             sel, sel_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RTY_W-1:0]   retry;
    logic               ack_l;

    logic               latch, pick, take, rty_inc, cnt_clr, cnt_inc;

    // Leaving a phase in which a coin was confirmed: skip GAP when it is empty.
    state_t             after_coin;
    assign after_coin = (GAP_LEN == 0) ? S_SELECT : S_GAP;

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        latch     = 1'b0;
        pick      = 1'b0;
        take      = 1'b0;
        rty_inc   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (load) begin
                    latch     = 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem5 != 4'd0)      sel_nxt = D5;
                else if (rem2 != 4'd0) sel_nxt = D2;
                else                   sel_nxt = D1;
                if ((rem5 | rem2 | rem1) != 4'd0) begin
                    pick      = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_EJECT;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_EJECT: begin
                if (cnt == CNT_W'(PULSE_LEN - 1)) begin
                    cnt_clr = 1'b1;
                    // A drop seen at any point during the pulse is the ack.
                    if (ack_l || coin_seen) begin
                        take      = 1'b1;
                        state_nxt = after_coin;
                    end else begin
                        state_nxt = S_WAIT_ACK;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (coin_seen) begin
                    take      = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = after_coin;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    cnt_clr   = 1'b1;
                    rty_inc   = 1'b1;
                    state_nxt = (retry < RTY_W'(MAX_RETRY)) ? S_EJECT : S_FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(GAP_LEN - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = S_SELECT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel    <= D1;
            cnt    <= '0;
            retry  <= '0;
            ack_l  <= 1'b0;
            rem1   <= 4'd0;
            rem2   <= 4'd0;
            rem5   <= 4'd0;
            eject1 <= 1'b0;
            eject2 <= 1'b0;
            eject5 <= 1'b0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);

            if (pick)         retry <= '0;
            else if (rty_inc) retry <= retry + RTY_W'(1);

            // Remember an early drop for the rest of the pulse; forget it
            // once the pulse is over.
            ack_l <= (state == S_EJECT) ? (ack_l | coin_seen) : 1'b0;

            if (latch) begin
                rem1 <= r1;
                rem2 <= r2;
                rem5 <= r5;
            end else if (take) begin
                unique case (sel)
                    D1:      if (rem1 != 4'd0) rem1 <= rem1 - 4'd1;
                    D2:      if (rem2 != 4'd0) rem2 <= rem2 - 4'd1;
                    D5:      if (rem5 != 4'd0) rem5 <= rem5 - 4'd1;
                    default: ;
                endcase
            end

            // Solenoids follow the next state so they rise and fall exactly
            // on the EJECT boundaries.
            eject1 <= (state_nxt == S_EJECT) && (sel_nxt == D1);
            eject2 <= (state_nxt == S_EJECT) && (sel_nxt == D2);
            eject5 <= (state_nxt == S_EJECT) && (sel_nxt == D5);
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. The stimulus process queues the
// events it expects (eject pulses, done, fault, busy falling); a monitor
// process detects those events on the DUT outputs and checks them in order.
module tb_change_dispenser;

    localparam int PULSE_LEN   = 4;
    localparam int ACK_TIMEOUT = 32;
    localparam int GAP_LEN     = 2;
    localparam int MAX_RETRY   = 2;

    localparam int K_EJECT = 0;
    localparam int K_DONE  = 1;
    localparam int K_FAULT = 2;
    localparam int K_BUSY  = 3;

    logic       clk;
    logic       rst, load, coin_seen, fault_clr;
    logic [3:0] r1, r2, r5;
    logic       eject1, eject2, eject5, busy, done, fault;
    logic [3:0] rem1, rem2, rem5;

    change_dispenser #(
        .PULSE_LEN(PULSE_LEN), .ACK_TIMEOUT(ACK_TIMEOUT),
        .GAP_LEN(GAP_LEN), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .r1(r1), .r2(r2), .r5(r5),
        .coin_seen(coin_seen), .fault_clr(fault_clr),
        .eject1(eject1), .eject2(eject2), .eject5(eject5),
        .busy(busy), .done(done), .fault(fault),
        .rem1(rem1), .rem2(rem2), .rem5(rem5)
    );

    typedef struct {
        int         kind;
        int         denom;
        int         width;   // pulse width, busy duration, or busy level for fault
        int         lead;    // low cycles before an eject pulse
        bit         chk_rem;
        logic [11:0] rem;    // {rem5, rem2, rem1}
        int         cyc;
    } ev_t;

    ev_t   exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    // Sensor behaviour: 0 silent, 1 ack 3 cycles after pulse falls (skipping
    // the first sens_skip pulses), 2 ack starting mid-pulse, held 6 cycles.
    int sens_mode = 0;
    int sens_skip = 0;
    int sens_gen  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual still running at %0t, required finish", $time);
        $fatal(1, "watchdog timeout");
    end

    function automatic int denom_of(input logic [2:0] v);
        if (v[2]) return 5;
        if (v[1]) return 2;
        return 1;
    endfunction

    task automatic got(input ev_t a);
        ev_t   e;
        string nm;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual kind=%0d denom=%0d width=%0d rem=%h cyc=%0d, required none",
                     a.kind, a.denom, a.width, a.rem, a.cyc);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.kind != a.kind || e.denom != a.denom ||
                (e.width >= 0 && e.width != a.width) ||
                (e.lead >= 0 && e.lead != a.lead) ||
                (e.chk_rem && e.rem != a.rem) ||
                (e.cyc >= 0 && e.cyc != a.cyc)) begin
                errors++;
                $display("FAIL %s: actual kind=%0d denom=%0d width=%0d lead=%0d rem=%h cyc=%0d, required kind=%0d denom=%0d width=%0d lead=%0d rem=%h cyc=%0d",
                         nm, a.kind, a.denom, a.width, a.lead, a.rem, a.cyc,
                         e.kind, e.denom, e.width, e.lead, e.rem, e.cyc);
            end
        end
    endtask

    // Monitor
    initial begin : monitor
        logic [2:0] cur, prev_e;
        logic       busy_prev, done_prev, fault_prev, done_follow;
        int         ew, lead_cnt, rise_lead, bdur;
        ev_t        a;
        prev_e = 3'b000; busy_prev = 1'b0; done_prev = 1'b0; fault_prev = 1'b0;
        done_follow = 1'b0; ew = 0; lead_cnt = 1000; rise_lead = 0; bdur = 0;
        forever begin
            @(negedge clk);
            cur = {eject5, eject2, eject1};
            a.lead = 0; a.chk_rem = 1'b1; a.cyc = cyc;
            a.rem = {rem5, rem2, rem1};
            if (cur != 3'b000) begin
                checks++;
                if (!$onehot(cur)) begin
                    errors++;
                    $display("FAIL eject_onehot: actual %b, required a single line", cur);
                end
                if (prev_e == 3'b000) rise_lead = lead_cnt;
                ew++;
            end else if (prev_e != 3'b000) begin
                a.kind = K_EJECT; a.denom = denom_of(prev_e);
                a.width = ew; a.lead = rise_lead;
                got(a);
                ew = 0;
                lead_cnt = 1;
            end else begin
                lead_cnt++;
            end
            prev_e = cur;

            if (done_follow) begin
                checks++;
                done_follow = 1'b0;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_then_idle: actual done=%b busy=%b, required done=0 busy=0", done, busy);
                end
            end
            if (done === 1'b1 && !done_prev) begin
                a.kind = K_DONE; a.denom = 0; a.width = 0; a.lead = 0;
                got(a);
                done_follow = 1'b1;
            end
            done_prev = done;

            if (fault === 1'b1 && !fault_prev) begin
                a.kind = K_FAULT; a.denom = 0; a.width = int'(busy); a.lead = 0;
                got(a);
            end
            fault_prev = fault;

            if (busy === 1'b1) bdur++;
            else if (busy_prev) begin
                a.kind = K_BUSY; a.denom = 0; a.width = bdur; a.lead = 0;
                got(a);
                bdur = 0;
            end
            busy_prev = busy;
        end
    end

    // Hopper sensor model
    initial begin : sensor
        logic [2:0] cur, sp;
        int         tmr, hold, skip_left, gen_seen;
        sp = 3'b000; tmr = 0; hold = 0; skip_left = 0; gen_seen = 0;
        coin_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_seen != sens_gen) begin
                gen_seen  = sens_gen;
                skip_left = sens_skip;
            end
            cur = {eject5, eject2, eject1};
            coin_seen = 1'b0;
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) coin_seen = 1'b1;
            end
            if (sens_mode == 1 && sp != 3'b000 && cur == 3'b000) begin
                if (skip_left > 0) skip_left--;
                else               tmr = 2;
            end
            if (sens_mode == 2 && sp == 3'b000 && cur != 3'b000) hold = 6;
            if (hold > 0) begin
                coin_seen = 1'b1;
                hold--;
            end
            if (sens_mode == 0) begin
                tmr = 0; hold = 0; coin_seen = 1'b0;
            end
            sp = cur;
        end
    end

    task automatic push(input string nm, input int kind, input int denom, input int width,
                        input int lead, input bit chk, input logic [11:0] rem, input int c);
        ev_t e;
        e.kind = kind; e.denom = denom; e.width = width; e.lead = lead;
        e.chk_rem = chk; e.rem = rem; e.cyc = c;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; load is sampled by the following posedge.
    task automatic fire_load(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a5);
        load = 1'b1; r1 = a1; r2 = a2; r5 = a5;
        @(negedge clk);
        load = 1'b0; r1 = 4'd0; r2 = 4'd0; r5 = 4'd0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: actual %0d events pending (next %s), required 0",
                     nm, exp_q.size(), name_q[0]);
            exp_q.delete();
            name_q.delete();
        end
        cycles(3);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_eject"}, int'({eject5, eject2, eject1}), 0);
        chk({pfx, "_busy"},  int'(busy),  0);
        chk({pfx, "_done"},  int'(done),  0);
        chk({pfx, "_fault"}, int'(fault), 0);
        chk({pfx, "_rem"},   int'({rem5, rem2, rem1}), 0);
    endtask

    initial begin : stim
        int k, n, rises;
        logic pe;
        rst = 1'b1; load = 1'b0; r1 = 4'd0; r2 = 4'd0; r5 = 4'd0; fault_clr = 1'b0;
        cycles(3);
        chk_all_zero("reset");
        rst = 1'b0;
        cycles(2);

        // 1: normal mix, order 5,2,1,1; lead = 3 ack delay + GAP + SELECT
        sens_mode = 1; sens_skip = 0; sens_gen++;
        push("t1_e5", K_EJECT, 5, PULSE_LEN, -1, 1, 12'h112, -1);
        push("t1_e2", K_EJECT, 2, PULSE_LEN, 3 + GAP_LEN + 1, 1, 12'h012, -1);
        push("t1_e1a", K_EJECT, 1, PULSE_LEN, 3 + GAP_LEN + 1, 1, 12'h002, -1);
        push("t1_e1b", K_EJECT, 1, PULSE_LEN, 3 + GAP_LEN + 1, 1, 12'h001, -1);
        push("t1_done", K_DONE, 0, 0, -1, 1, 12'h000, -1);
        push("t1_busy", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fire_load(4'd2, 4'd1, 4'd1);
        drain("t1_drain", 400);
        chk("t1_fault", int'(fault), 0);

        // 2: zero change, done after edge k+1, busy 2 cycles
        sens_mode = 0; sens_gen++;
        k = cyc + 1;
        push("t2_done", K_DONE, 0, 0, -1, 1, 12'h000, k + 1);
        push("t2_busy", K_BUSY, 0, 2, -1, 0, 12'h000, -1);
        fire_load(4'd0, 4'd0, 4'd0);
        drain("t2_drain", 20);

        // 3: jam, 1+MAX_RETRY pulses each followed by ACK_TIMEOUT cycles
        push("t3_e2a", K_EJECT, 2, PULSE_LEN, -1, 1, 12'h010, -1);
        push("t3_e2b", K_EJECT, 2, PULSE_LEN, ACK_TIMEOUT, 1, 12'h010, -1);
        push("t3_e2c", K_EJECT, 2, PULSE_LEN, ACK_TIMEOUT, 1, 12'h010, -1);
        push("t3_fault", K_FAULT, 0, 1, -1, 1, 12'h010, -1);
        fire_load(4'd0, 4'd1, 4'd0);
        drain("t3_drain", 300);
        chk("t3_fault_held", int'(fault), 1);
        chk("t3_busy_held", int'(busy), 1);
        chk("t3_done_low", int'(done), 0);
        fire_load(4'd5, 4'd0, 4'd0);
        cycles(4);
        chk("t3_load_ignored", int'({rem5, rem2, rem1}), 12'h010);
        chk("t3_fault_after_load", int'(fault), 1);
        push("t3_busy", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("t3_clr_fault", int'(fault), 0);
        chk("t3_clr_busy", int'(busy), 0);
        chk("t3_rem_kept", int'({rem5, rem2, rem1}), 12'h010);
        drain("t3_clr_drain", 5);
        k = cyc + 1;
        push("t3_reload_done", K_DONE, 0, 0, -1, 1, 12'h000, k + 1);
        push("t3_reload_busy", K_BUSY, 0, 2, -1, 0, 12'h000, -1);
        fire_load(4'd0, 4'd0, 4'd0);
        drain("t3_reload_drain", 20);

        // 4: first attempt unacknowledged, second acknowledged
        sens_mode = 1; sens_skip = 1; sens_gen++;
        push("t4_e1a", K_EJECT, 1, PULSE_LEN, -1, 1, 12'h001, -1);
        push("t4_e1b", K_EJECT, 1, PULSE_LEN, ACK_TIMEOUT, 1, 12'h001, -1);
        push("t4_done", K_DONE, 0, 0, -1, 1, 12'h000, -1);
        push("t4_busy", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fire_load(4'd1, 4'd0, 4'd0);
        drain("t4_drain", 300);
        chk("t4_fault", int'(fault), 0);

        // 5: ack during the pulse, held 6 cycles; counts once per coin
        sens_mode = 2; sens_skip = 0; sens_gen++;
        push("t5_e5a", K_EJECT, 5, PULSE_LEN, -1, 1, 12'h100, -1);
        push("t5_e5b", K_EJECT, 5, PULSE_LEN, GAP_LEN + 1, 1, 12'h000, -1);
        push("t5_done", K_DONE, 0, 0, -1, 1, 12'h000, -1);
        push("t5_busy", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fire_load(4'd0, 4'd0, 4'd2);
        drain("t5_drain", 200);

        // 6: reset during the second pulse, then a load while busy
        sens_mode = 1; sens_skip = 0; sens_gen++;
        push("t6_e2a", K_EJECT, 2, PULSE_LEN, -1, 1, 12'h020, -1);
        push("t6_e2_cut", K_EJECT, 2, 2, 3 + GAP_LEN + 1, 1, 12'h000, -1);
        push("t6_busy_rst", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fire_load(4'd0, 4'd2, 4'd0);
        n = 0; rises = 0; pe = 1'b0;
        while (rises < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (eject2 && !pe) rises++;
            pe = eject2;
        end
        chk("t6_second_pulse_seen", rises, 2);
        @(negedge clk);
        #2;
        sens_mode = 0; sens_gen++;
        rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain("t6_rst_drain", 5);

        sens_mode = 1; sens_skip = 0; sens_gen++;
        push("t6_e1a", K_EJECT, 1, PULSE_LEN, -1, 1, 12'h003, -1);
        push("t6_e1b", K_EJECT, 1, PULSE_LEN, 3 + GAP_LEN + 1, 1, 12'h002, -1);
        push("t6_e1c", K_EJECT, 1, PULSE_LEN, 3 + GAP_LEN + 1, 1, 12'h001, -1);
        push("t6_done", K_DONE, 0, 0, -1, 1, 12'h000, -1);
        push("t6_busy", K_BUSY, 0, -1, -1, 0, 12'h000, -1);
        fire_load(4'd3, 4'd0, 4'd0);
        n = 0;
        while (!eject1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_eject_started", int'(eject1), 1);
        fire_load(4'd9, 4'd0, 4'd0);
        drain("t6_drain", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending controller `maybanhang`.
- Takes the change counts the controller computes (r1, r2, r5: number of 1-, 2- and 5-unit coins to return) and drives the coin-hopper ejector solenoids one coin at a time.
- Each ejection is confirmed against the hopper's coin-drop sensor, with a timeout and limited retries.
- Reports progress, completion and a latched hopper fault.

Parameters:
PULSE_LEN, 4, cycles each eject output is held high per attempt (>=1)
ACK_TIMEOUT, 32, cycles to wait for coin_seen after the pulse ends before the attempt counts as failed (>=1)
GAP_LEN, 2, idle cycles after a confirmed coin before the next ejection (>=0)
MAX_RETRY, 2, extra attempts per coin after the first failed one

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load  input  1  one-cycle strobe: latch r1/r2/r5 and start dispensing
r1  input  4  number of 1-unit coins to return
r2  input  4  number of 2-unit coins to return
r5  input  4  number of 5-unit coins to return
coin_seen  input  1  hopper drop sensor, already synchronous to clk, high >=1 cycle per coin
fault_clr  input  1  clears a latched fault, returns block to IDLE
eject1  output  1  1-unit solenoid drive
eject2  output  1  2-unit solenoid drive
eject5  output  1  5-unit solenoid drive
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when all requested coins are confirmed
fault  output  1  latched: a coin failed MAX_RETRY+1 attempts
rem1  output  4  1-unit coins still owed
rem2  output  4  2-unit coins still owed
rem5  output  4  5-unit coins still owed

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0: eject*, busy, done, fault, rem1/rem2/rem5.
  - Internal pulse, timeout, gap and retry counters cleared.
  - An eject that is mid-pulse drops immediately.
- States: IDLE, SELECT, EJECT, WAIT_ACK, GAP, DONE, FAULT.
- IDLE: on load=1 at edge k, latch rem1<=r1, rem2<=r2, rem5<=r5, go to SELECT; busy=1 from after edge k.
- IDLE with load=0: remain in IDLE.
- load while not in IDLE: ignored, latched counts unchanged.
- SELECT (1 cycle): pick the denomination in the order 5, then 2, then 1, taking the first with a nonzero remaining count.
  - Coin available: retry count cleared, go to EJECT.
  - All three counts zero: go to DONE. A load of 0/0/0 gives done high in cycle k+2, i.e. asserted after edge k+1.
- EJECT: only the selected eject line is high, for exactly PULSE_LEN cycles, then WAIT_ACK.
  - Eject lines are registered.
  - Never more than one eject line is high at once.
- WAIT_ACK: timeout counter runs from 0.
  - coin_seen=1: decrement the selected rem, go to GAP (or SELECT directly if GAP_LEN=0).
  - ACK_TIMEOUT cycles with no coin_seen: increment retry count. If retry <= MAX_RETRY go back to EJECT; otherwise go to FAULT.
  - A coin_seen held for several cycles counts once: the FSM has already left WAIT_ACK.
- coin_seen during EJECT counts as the acknowledgement.
  - Latch it; on pulse end, decrement the selected rem and go to GAP without entering WAIT_ACK.
- coin_seen in IDLE, SELECT, GAP, DONE or FAULT: ignored, no count change.
- GAP: GAP_LEN cycles with all ejects low, then SELECT.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE. busy falls the next cycle.
- FAULT:
  - fault=1, busy=1, all ejects low.
  - rem* hold the counts still owed, with the failed coin not decremented.
  - Stays until fault_clr=1, which goes to IDLE with fault=0. rem* are kept for diagnostics until the next load.
  - load in FAULT is ignored.
- Arithmetic:
  - rem* are 4-bit, only decremented when nonzero; no wrap.
  - The timeout counter is wide enough for ACK_TIMEOUT; the retry counter is wide enough for MAX_RETRY+1.
- fault_clr outside FAULT: no effect.

Test Plan:
1. Normal mix. rst pulse, then load with r5=1, r2=1, r1=2; sensor model raises coin_seen 3 cycles after each pulse falls.
   -> Pulse order eject5, eject2, eject1, eject1, each 4 cycles wide with a 2-cycle gap.
   -> rem5/rem2/rem1 reach 0; done is a single pulse; busy is low the cycle after done; fault stays 0.
2. Zero change: load with r1=r2=r5=0.
   -> No eject; done is high exactly 2 cycles after the load edge; busy is high for 2 cycles.
3. Hopper jam: load r2=1, coin_seen never asserted.
   -> eject2 pulses 3 times (1+MAX_RETRY), each followed by 32 timeout cycles.
   -> fault=1, rem2=1, busy=1, no done.
   -> fault_clr gives fault=0, busy=0; a following load is accepted.
4. Retry recovery: load r1=1; no ack on the first attempt, coin_seen on the second.
   -> Two eject1 pulses, rem1=0, done pulse, fault=0.
5. Early ack and long ack: coin_seen arrives mid-EJECT and is held for 6 cycles, with r5=2.
   -> rem5 decrements by exactly 1 per coin; two eject5 pulses; done.
6. Reset and load during busy. Assert rst during the 2nd eject pulse.
   -> All outputs 0 immediately.
   -> After reset, load r1=3. A second load with r1=9 during dispensing is ignored: exactly 3 eject1 pulses.
